// File: rtl/seg14_pkg.sv
// seg14_pkg: shared widths, 14-segment glyph constants and the code-to-glyph decode.
// Segment bit order (bit 13 .. bit 0): a b c d e f g1 g2 h i j k l m.
//   h = upper-left diagonal, i = upper vertical, j = upper-right diagonal,
//   k = lower-left diagonal, l = lower vertical, m = lower-right diagonal.
package seg14_pkg;

    localparam int CHAR_W = 6;
    localparam int SEG_W  = 14;

    // Glyphs written as  abcdef_g1g2_hijklm
    localparam logic [SEG_W-1:0] SEG_SPACE = 14'b000000_00_000000;
    localparam logic [SEG_W-1:0] SEG_A     = 14'b111011_11_000000;
    localparam logic [SEG_W-1:0] SEG_B     = 14'b111100_01_010010;
    localparam logic [SEG_W-1:0] SEG_C     = 14'b100111_00_000000;
    localparam logic [SEG_W-1:0] SEG_D     = 14'b111100_00_010010;
    localparam logic [SEG_W-1:0] SEG_E     = 14'b100111_11_000000;
    localparam logic [SEG_W-1:0] SEG_F     = 14'b100011_10_000000;
    localparam logic [SEG_W-1:0] SEG_G     = 14'b101111_01_000000;
    localparam logic [SEG_W-1:0] SEG_H     = 14'b011011_11_000000;
    localparam logic [SEG_W-1:0] SEG_I     = 14'b100100_00_010010;
    localparam logic [SEG_W-1:0] SEG_J     = 14'b011110_00_000000;
    localparam logic [SEG_W-1:0] SEG_K     = 14'b000011_10_001001;
    localparam logic [SEG_W-1:0] SEG_L     = 14'b000111_00_000000;
    localparam logic [SEG_W-1:0] SEG_M     = 14'b011011_00_101000;
    localparam logic [SEG_W-1:0] SEG_N     = 14'b011011_00_100001;
    localparam logic [SEG_W-1:0] SEG_O     = 14'b111111_00_000000;
    localparam logic [SEG_W-1:0] SEG_P     = 14'b110011_11_000000;
    localparam logic [SEG_W-1:0] SEG_Q     = 14'b111111_00_000001;
    localparam logic [SEG_W-1:0] SEG_R     = 14'b110011_11_000001;
    localparam logic [SEG_W-1:0] SEG_S     = 14'b101101_11_000000;
    localparam logic [SEG_W-1:0] SEG_T     = 14'b100000_00_010010;
    localparam logic [SEG_W-1:0] SEG_U     = 14'b011111_00_000000;
    localparam logic [SEG_W-1:0] SEG_V     = 14'b000011_00_001100;
    localparam logic [SEG_W-1:0] SEG_W_    = 14'b011011_00_000101;
    localparam logic [SEG_W-1:0] SEG_X     = 14'b000000_00_101101;
    localparam logic [SEG_W-1:0] SEG_Y     = 14'b000000_00_101010;
    localparam logic [SEG_W-1:0] SEG_Z     = 14'b100100_00_001100;
    localparam logic [SEG_W-1:0] SEG_0     = 14'b111111_00_001100;
    localparam logic [SEG_W-1:0] SEG_1     = 14'b011000_00_001000;
    localparam logic [SEG_W-1:0] SEG_2     = 14'b110110_11_000000;
    localparam logic [SEG_W-1:0] SEG_3     = 14'b111100_01_000000;
    localparam logic [SEG_W-1:0] SEG_4     = 14'b011001_11_000000;
    localparam logic [SEG_W-1:0] SEG_5     = 14'b100101_10_000001;
    localparam logic [SEG_W-1:0] SEG_6     = 14'b101111_11_000000;
    localparam logic [SEG_W-1:0] SEG_7     = 14'b111000_00_000000;
    localparam logic [SEG_W-1:0] SEG_8     = 14'b111111_11_000000;
    localparam logic [SEG_W-1:0] SEG_9     = 14'b111101_11_000000;

    // Codes 1..26 are letters, 32..41 are digits; everything else is blank.
    function automatic logic [SEG_W-1:0] seg14_font(input logic [CHAR_W-1:0] code);
        logic [SEG_W-1:0] seg;
        seg = SEG_SPACE;
        case (code)
            6'd1:  seg = SEG_A;
            6'd2:  seg = SEG_B;
            6'd3:  seg = SEG_C;
            6'd4:  seg = SEG_D;
            6'd5:  seg = SEG_E;
            6'd6:  seg = SEG_F;
            6'd7:  seg = SEG_G;
            6'd8:  seg = SEG_H;
            6'd9:  seg = SEG_I;
            6'd10: seg = SEG_J;
            6'd11: seg = SEG_K;
            6'd12: seg = SEG_L;
            6'd13: seg = SEG_M;
            6'd14: seg = SEG_N;
            6'd15: seg = SEG_O;
            6'd16: seg = SEG_P;
            6'd17: seg = SEG_Q;
            6'd18: seg = SEG_R;
            6'd19: seg = SEG_S;
            6'd20: seg = SEG_T;
            6'd21: seg = SEG_U;
            6'd22: seg = SEG_V;
            6'd23: seg = SEG_W_;
            6'd24: seg = SEG_X;
            6'd25: seg = SEG_Y;
            6'd26: seg = SEG_Z;
            6'd32: seg = SEG_0;
            6'd33: seg = SEG_1;
            6'd34: seg = SEG_2;
            6'd35: seg = SEG_3;
            6'd36: seg = SEG_4;
            6'd37: seg = SEG_5;
            6'd38: seg = SEG_6;
            6'd39: seg = SEG_7;
            6'd40: seg = SEG_8;
            6'd41: seg = SEG_9;
            default: seg = SEG_SPACE;
        endcase
        return seg;
    endfunction

endpackage

// File: rtl/seg14_font_rom.sv
// seg14_font_rom: combinational character-code to 14-segment pattern decode.
module seg14_font_rom
    import seg14_pkg::*;
(
    input  logic [CHAR_W-1:0] code,
    output logic [SEG_W-1:0]  seg
);

    // Pure table lookup; the caller registers the result.
    assign seg = seg14_font(code);

endmodule

// File: rtl/seg14_scroll_scanner.sv
// seg14_scroll_scanner: multiplexed 14-segment display driver with a writable
// message buffer and optional scrolling across the digits.
// Build option: define SEG14_DIM_EN to add the 4-bit bright input and PWM
// dimming of the digit selects (segments are never dimmed).
module seg14_scroll_scanner
    import seg14_pkg::*;
#(
    parameter int N_DIGITS    = 12,
    parameter int MSG_LEN     = 32,
    parameter int SCAN_DIV    = 1,
    parameter int SCROLL_FRMS = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [CHAR_W-1:0]          wr_char,
    input  logic                       scroll_en,
`ifdef SEG14_DIM_EN
    input  logic [3:0]                 bright,
`endif
    input  logic                       offset_clr,
    output logic [N_DIGITS-1:0]        sel,
    output logic [SEG_W-1:0]           segm,
    output logic                       frame_tick
);

    localparam int AW = $clog2(MSG_LEN);
    localparam int SW = AW + 1;
    localparam int DW = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int FW = (SCROLL_FRMS > 1) ? $clog2(SCROLL_FRMS) : 1;

    logic [DW-1:0]     digit_reg, digit_next;
    logic [CW-1:0]     div_cnt_reg, div_cnt_next;
    logic [FW-1:0]     frame_cnt_reg, frame_cnt_next;
    logic [AW-1:0]     offset_reg, offset_next;
    logic              div_wrap;
    logic              last_digit;
    logic              frame_end;

    logic [CHAR_W-1:0] buf_reg [MSG_LEN];
    logic [SW-1:0]     rd_sum;
    logic [AW-1:0]     rd_idx;
    logic [CHAR_W-1:0] rd_char;
    logic [SEG_W-1:0]  rd_seg;
    logic [N_DIGITS-1:0] onehot;
    logic              dim_on;

    logic [N_DIGITS-1:0] sel_reg;
    logic [SEG_W-1:0]    segm_reg;
    logic                frame_tick_reg;

    assign div_wrap   = (div_cnt_reg == CW'(SCAN_DIV - 1));
    assign last_digit = (digit_reg == DW'(N_DIGITS - 1));
    assign frame_end  = div_wrap && last_digit;

    // Next-state for scan divider, digit, frame counter and scroll offset.
    // The offset only moves on a frame end so a frame never mixes two offsets.
    always_comb begin
        div_cnt_next   = div_cnt_reg;
        digit_next     = digit_reg;
        frame_cnt_next = frame_cnt_reg;
        offset_next    = offset_reg;

        if (div_wrap) begin
            div_cnt_next = '0;
            digit_next   = last_digit ? '0 : digit_reg + DW'(1);
        end else begin
            div_cnt_next = div_cnt_reg + CW'(1);
        end

        if (offset_clr) begin
            offset_next    = '0;
            frame_cnt_next = '0;
        end else if (frame_end) begin
            if (frame_cnt_reg == FW'(SCROLL_FRMS - 1)) begin
                frame_cnt_next = '0;
                if (scroll_en) begin
                    offset_next = (offset_reg == AW'(MSG_LEN - 1)) ? '0 : offset_reg + AW'(1);
                end
            end else begin
                frame_cnt_next = frame_cnt_reg + FW'(1);
            end
        end
    end

    // Counter state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            digit_reg     <= '0;
            div_cnt_reg   <= '0;
            frame_cnt_reg <= '0;
            offset_reg    <= '0;
        end else begin
            digit_reg     <= digit_next;
            div_cnt_reg   <= div_cnt_next;
            frame_cnt_reg <= frame_cnt_next;
            offset_reg    <= offset_next;
        end
    end

    // Message buffer: flat registers so reset can blank every entry at once.
    // Addresses at or beyond MSG_LEN match no entry and are dropped.
    always_ff @(posedge clk) begin
        for (int i = 0; i < MSG_LEN; i++) begin
            if (rst) begin
                buf_reg[i] <= '0;
            end else if (wr_en && (wr_addr == AW'(i))) begin
                buf_reg[i] <= wr_char;
            end
        end
    end

    // Buffer read index: offset+digit is below 2*MSG_LEN, so one conditional
    // subtract is an exact modulo for any MSG_LEN.
    assign rd_sum  = SW'(offset_reg) + SW'(digit_reg);
    assign rd_idx  = (rd_sum >= SW'(MSG_LEN)) ? AW'(rd_sum - SW'(MSG_LEN)) : AW'(rd_sum);
    assign rd_char = buf_reg[rd_idx];

    seg14_font_rom u_font_rom (
        .code (rd_char),
        .seg  (rd_seg)
    );

    // One-hot decode of the current digit.
    generate
        for (genvar gi = 0; gi < N_DIGITS; gi++) begin : g_sel
            assign onehot[gi] = (digit_reg == DW'(gi));
        end
    endgenerate

`ifdef SEG14_DIM_EN
    logic [3:0] pwm_cnt_reg;

    // Free-running PWM phase; selects are enabled for bright+1 of 16 phases.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_cnt_reg <= '0;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 4'd1;
        end
    end

    assign dim_on = (pwm_cnt_reg <= bright);
`else
    assign dim_on = 1'b1;
`endif

    // Output registers: everything the pads see lands together, one cycle
    // after the digit state that produced it. A write to the address being
    // read this cycle is not visible until the next read of that address.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_reg        <= '0;
            segm_reg       <= '0;
            frame_tick_reg <= 1'b0;
        end else begin
            sel_reg        <= dim_on ? onehot : '0;
            segm_reg       <= rd_seg;
            frame_tick_reg <= frame_end;
        end
    end

    assign sel        = sel_reg;
    assign segm       = segm_reg;
    assign frame_tick = frame_tick_reg;

endmodule

// File: tb/tb_seg14_scroll_scanner.sv
// tb_seg14_scroll_scanner: randomized + directed bench with a cycle-level
// reference model of the scanner built from scan arithmetic and a plain buffer array.
module tb_seg14_scroll_scanner;
    import seg14_pkg::*;

    localparam int N  = 12;
    localparam int ML = 20;
    localparam int SD = 2;
    localparam int SF = 2;
    localparam int AW = $clog2(ML);

    logic              clk = 1'b0;
    logic              rst;
    logic              wr_en;
    logic [AW-1:0]     wr_addr;
    logic [CHAR_W-1:0] wr_char;
    logic              scroll_en;
    logic              offset_clr;
`ifdef SEG14_DIM_EN
    logic [3:0]        bright;
`endif
    logic [N-1:0]      sel;
    logic [SEG_W-1:0]  segm;
    logic              frame_tick;

    seg14_scroll_scanner #(
        .N_DIGITS    (N),
        .MSG_LEN     (ML),
        .SCAN_DIV    (SD),
        .SCROLL_FRMS (SF)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_char    (wr_char),
        .scroll_en  (scroll_en),
`ifdef SEG14_DIM_EN
        .bright     (bright),
`endif
        .offset_clr (offset_clr),
        .sel        (sel),
        .segm       (segm),
        .frame_tick (frame_tick)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int pass_cnt  = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    endtask

    // Glyph table built straight from the named constants.
    logic [SEG_W-1:0] font_tbl [64];
    logic [SEG_W-1:0] letters [26] = '{SEG_A, SEG_B, SEG_C, SEG_D, SEG_E, SEG_F, SEG_G,
        SEG_H, SEG_I, SEG_J, SEG_K, SEG_L, SEG_M, SEG_N, SEG_O, SEG_P, SEG_Q, SEG_R,
        SEG_S, SEG_T, SEG_U, SEG_V, SEG_W_, SEG_X, SEG_Y, SEG_Z};
    logic [SEG_W-1:0] numerals [10] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4,
        SEG_5, SEG_6, SEG_7, SEG_8, SEG_9};

    initial begin
        for (int i = 0; i < 64; i++) font_tbl[i] = '0;
        for (int i = 0; i < 26; i++) font_tbl[1 + i] = letters[i];
        for (int i = 0; i < 10; i++) font_tbl[32 + i] = numerals[i];
    end

    // Reference model: m_t = cycles into the current scan (digit = t/SD mod N).
    int           m_t, m_off, m_frames, m_pwm, m_d;
    bit           m_last;
    int           m_buf [ML];
    bit           model_valid = 1'b0;
    logic [N-1:0]     exp_sel;
    logic [SEG_W-1:0] exp_segm;
    logic             exp_tick;

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                model_valid = 1'b1;
                m_t = 0; m_off = 0; m_frames = 0; m_pwm = 0;
                for (int i = 0; i < ML; i++) m_buf[i] = 0;
                exp_sel = '0; exp_segm = '0; exp_tick = 1'b0;
            end else if (model_valid) begin
                m_d    = (m_t / SD) % N;
                m_last = ((m_t % SD) == SD - 1) && (m_d == N - 1);
                exp_sel = '0;
                exp_sel[m_d] = 1'b1;
`ifdef SEG14_DIM_EN
                if (m_pwm > int'(bright)) exp_sel = '0;
                m_pwm = (m_pwm + 1) % 16;
`endif
                exp_segm = font_tbl[m_buf[(m_off + m_d) % ML]];
                exp_tick = m_last;
                if (wr_en && int'(wr_addr) < ML) m_buf[wr_addr] = int'(wr_char);
                if (offset_clr) begin
                    m_off = 0;
                    m_frames = 0;
                end else if (m_last) begin
                    m_frames++;
                    if (m_frames == SF) begin
                        m_frames = 0;
                        if (scroll_en) m_off = (m_off + 1) % ML;
                    end
                end
                m_t = (m_t + 1) % (N * SD);
            end
        end
    end

    // Compare process: every cycle once the model has seen a reset.
    initial begin
        forever begin
            @(negedge clk);
            if (model_valid) begin
                chk("sel", 32'(sel), 32'(exp_sel));
                chk("segm", 32'(segm), 32'(exp_segm));
                chk("frame_tick", 32'(frame_tick), 32'(exp_tick));
            end
        end
    end

    function automatic logic [CHAR_W-1:0] ch2code(input byte c);
        if (c >= "A" && c <= "Z") return CHAR_W'(c - 64);
        if (c >= "0" && c <= "9") return CHAR_W'(c - 48 + 32);
        return '0;
    endfunction

    task automatic do_write(input int addr, input logic [CHAR_W-1:0] ch);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(addr); wr_char = ch;
        $display("write addr=%0d char=%0d", addr, ch);
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic write_msg(input string s);
        for (int i = 0; i < s.len(); i++) do_write(i, ch2code(s[i]));
    endtask

    // Wait (bounded) until sel equals v; with fresh=1 first wait for it to leave v.
    task automatic wait_sel(input logic [N-1:0] v, input bit fresh);
        int n;
        n = 0;
        if (fresh) while (sel === v && n < 500) begin @(negedge clk); n++; end
        while (sel !== v && n < 500) begin @(negedge clk); n++; end
        chk("wait_sel", 32'(sel), 32'(v));
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (frame_tick !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    endtask

    logic [SEG_W-1:0] seg_or;
    int t0, cnt;

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_char = '0;
        scroll_en = 1'b0; offset_clr = 1'b0;
`ifdef SEG14_DIM_EN
        bright = 4'd15;
`endif
        repeat (3) @(negedge clk);
        rst = 1'b0;
        write_msg("BROTHING1201");

        // Reset wipes the message and blanks the outputs.
        @(negedge clk); rst = 1'b1;
        @(negedge clk);
        chk("rst_sel", 32'(sel), 32'h0);
        chk("rst_segm", 32'(segm), 32'h0);
        chk("rst_tick", 32'(frame_tick), 32'h0);
        $display("reset applied");
        rst = 1'b0;
        seg_or = '0;
        repeat (N * SD) begin @(negedge clk); seg_or |= segm; end
        chk("blank_after_rst", 32'(seg_or), 32'h0);

        // Rewrite and watch a full scan: 'B' on digit 0, sel walks SD clks per digit.
        write_msg("BROTHING1201");
        wait_sel(12'h001, 1'b1);
        chk("B_at_digit0", 32'(segm), 32'h3C52);
        for (int k = 0; k < N * SD; k++) begin
            chk("walk", 32'(sel), 32'(1) << (k / SD));
            @(negedge clk);
        end

        // frame_tick period.
        wait_tick();
        t0 = cyc;
        @(negedge clk);
        wait_tick();
        chk("tick_period", 32'(cyc - t0), 32'(N * SD));

        // offset_clr held across a scroll step.
        scroll_en = 1'b1;
        wait_tick();
        offset_clr = 1'b1;
        $display("offset_clr held over scroll step");
        repeat (N * SD * SF + 2) @(negedge clk);
        offset_clr = 1'b0;

        // Out-of-range write ignored; code 50 blanks.
        scroll_en = 1'b0;
        do_write(ML, 6'd2);
        do_write(0, 6'd50);
        @(negedge clk); offset_clr = 1'b1;
        @(negedge clk); offset_clr = 1'b0;
        wait_sel(12'h001, 1'b1);
        chk("code50_blank", 32'(segm), 32'h0);

        // Reset mid-frame at digit 7.
        wait_sel(12'h080, 1'b0);
        rst = 1'b1;
        $display("reset at digit 7");
        @(negedge clk);
        chk("midrst_sel", 32'(sel), 32'h0);
        rst = 1'b0;
        @(negedge clk);
        chk("restart_sel", 32'(sel), 32'h001);

`ifdef SEG14_DIM_EN
        bright = 4'd3;
        repeat (2) @(negedge clk);
        cnt = 0;
        repeat (16) begin
            if (sel != '0) cnt++;
            @(negedge clk);
        end
        chk("dim_duty", 32'(cnt), 32'd4);
        bright = 4'd15;
`endif

        // Random phase: writes (some out of range), scroll toggles, clears, resets.
        scroll_en = 1'b1;
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            rst        = ($urandom_range(0, 1499) == 0);
            wr_en      = ($urandom_range(0, 3) == 0);
            wr_addr    = AW'($urandom_range(0, 31));
            wr_char    = CHAR_W'($urandom_range(0, 63));
            offset_clr = ($urandom_range(0, 1999) == 0);
            if ($urandom_range(0, 499) == 0) scroll_en = ~scroll_en;
`ifdef SEG14_DIM_EN
            if ($urandom_range(0, 199) == 0) bright = 4'($urandom_range(0, 15));
`endif
        end

        // Long scroll run so the offset wraps past MSG_LEN-1.
        rst = 1'b0; offset_clr = 1'b0; scroll_en = 1'b1;
        $display("scroll wrap phase");
        for (int c = 0; c < 1500; c++) begin
            @(negedge clk);
            wr_en   = ($urandom_range(0, 7) == 0);
            wr_addr = AW'($urandom_range(0, 31));
            wr_char = CHAR_W'($urandom_range(0, 63));
        end
        wr_en = 1'b0;
        repeat (4) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
